// File: rtl/router_pkg.sv
//------------------------------------------------------------------------------
// router_pkg : shared router constants and the output-port grant state type.
// Rev 1.0 -- initial release
//------------------------------------------------------------------------------
`default_nettype none

package router_pkg;

  localparam int NUM_PORTS = 16;
  localparam int PORT_ID_W = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } grant_state_e;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
//------------------------------------------------------------------------------
// rr_pick : combinational round-robin picker; first set req at or above ptr.
// Rev 1.0 -- initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_pick
  import router_pkg::*;
#(
  parameter int NUM_IN = NUM_PORTS,
  parameter int ID_W   = PORT_ID_W
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [ID_W-1:0]   ptr,
  output logic              found,
  output logic [NUM_IN-1:0] winner,
  output logic [ID_W-1:0]   winner_id
);

  logic [ID_W-1:0] idx;

  // Index arithmetic in ID_W bits gives the 15->0 wrap for free.
  always_comb begin
    found     = 1'b0;
    winner    = '0;
    winner_id = '0;
    idx       = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      idx = ptr + ID_W'(i);
      if (!found && req[idx]) begin
        found       = 1'b1;
        winner[idx] = 1'b1;
        winner_id   = idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/output_port_grant.sv
//------------------------------------------------------------------------------
// output_port_grant : round-robin grant FSM for one router output port.
// Optional hold limit enabled by OUTPUT_PORT_GRANT_TIMEOUT_EN.
// Rev 1.0 -- initial release
//------------------------------------------------------------------------------
`default_nettype none

module output_port_grant
  import router_pkg::*;
#(
  parameter int NUM_IN   = NUM_PORTS,
  parameter int MAX_HOLD = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_IN-1:0]          req,
  input  logic [NUM_IN-1:0]          done,
  output logic [NUM_IN-1:0]          grant,
  output logic [$clog2(NUM_IN)-1:0]  grant_id,
  output logic                       busy
`ifdef OUTPUT_PORT_GRANT_TIMEOUT_EN
  ,
  output logic                       timeout
`endif
);

  localparam int ID_W = $clog2(NUM_IN);

  grant_state_e      state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [NUM_IN-1:0] grant_q, grant_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;

  logic              pick_found;
  logic [NUM_IN-1:0] pick_winner;
  logic [ID_W-1:0]   pick_id;

`ifdef OUTPUT_PORT_GRANT_TIMEOUT_EN
  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);
  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;
`else
  // The hold limit has no effect without the counter.
  if (MAX_HOLD < 0) begin : g_max_hold_unused
  end
`endif

  rr_pick #(
    .NUM_IN (NUM_IN),
    .ID_W   (ID_W)
  ) u_rr_pick (
    .req       (req),
    .ptr       (ptr_q),
    .found     (pick_found),
    .winner    (pick_winner),
    .winner_id (pick_id)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
`ifdef OUTPUT_PORT_GRANT_TIMEOUT_EN
    cnt_d      = cnt_q;
    timeout_d  = 1'b0;
`endif
    if (state_q == IDLE) begin
      if (pick_found) begin
        state_d    = HOLD;
        grant_d    = pick_winner;
        grant_id_d = pick_id;
        ptr_d      = pick_id + ID_W'(1);
`ifdef OUTPUT_PORT_GRANT_TIMEOUT_EN
        cnt_d      = '0;
`endif
      end
    end else begin
      // Only the granted input's done ends the hold; done wins over the limit.
      if (done[grant_id_q]) begin
        state_d    = IDLE;
        grant_d    = '0;
        grant_id_d = '0;
      end
`ifdef OUTPUT_PORT_GRANT_TIMEOUT_EN
      else if (cnt_q == HOLD_LIMIT) begin
        state_d    = IDLE;
        grant_d    = '0;
        grant_id_d = '0;
        timeout_d  = 1'b1;
      end else begin
        cnt_d      = cnt_q + 8'd1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      grant_q    <= '0;
      grant_id_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
    end
  end

`ifdef OUTPUT_PORT_GRANT_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`endif

  assign grant    = grant_q;
  assign grant_id = grant_id_q;
  assign busy     = (state_q == HOLD);

endmodule

`default_nettype wire

// File: tb/tb_output_port_grant.sv
//------------------------------------------------------------------------------
// tb_output_port_grant : directed + random checks against a behavioural model.
// Rev 1.0 -- initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_output_port_grant;

  localparam int N  = 16;
  localparam int MH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  done = '0;
  logic [N-1:0]  grant;
  logic [3:0]    grant_id;
  logic          busy;
`ifdef OUTPUT_PORT_GRANT_TIMEOUT_EN
  logic          timeout;
`endif

  int compared   = 0;
  int mismatched = 0;

  // Reference model: holder index (-1 when free), priority start, hold age.
  int m_hold = -1;
  int m_ptr  = 0;
  int m_cnt  = 0;
  int m_to   = 0;

  output_port_grant #(.NUM_IN(N), .MAX_HOLD(MH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .done     (done),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy)
`ifdef OUTPUT_PORT_GRANT_TIMEOUT_EN
    ,
    .timeout  (timeout)
`endif
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hold = -1; m_ptr = 0; m_cnt = 0; m_to = 0;
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] d);
    bit timeout_en;
`ifdef OUTPUT_PORT_GRANT_TIMEOUT_EN
    timeout_en = 1'b1;
`else
    timeout_en = 1'b0;
`endif
    m_to = 0;
    if (m_hold < 0) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (m_hold < 0 && r[idx]) m_hold = idx;
      end
      if (m_hold >= 0) begin
        m_ptr = (m_hold + 1) % N;
        m_cnt = 0;
      end
    end else if (d[m_hold]) begin
      m_hold = -1;
    end else if (timeout_en && m_cnt == MH) begin
      m_hold = -1;
      m_to   = 1;
    end else begin
      m_cnt++;
    end
  endtask

  task automatic check_all(input string tag);
    logic [N-1:0] eg;
    eg = (m_hold < 0) ? '0 : (N'(1) << m_hold);
    cmp({tag, ".grant"},    32'(grant),    32'(eg));
    cmp({tag, ".grant_id"}, 32'(grant_id), (m_hold < 0) ? 32'd0 : 32'(m_hold));
    cmp({tag, ".busy"},     32'(busy),     (m_hold < 0) ? 32'd0 : 32'd1);
`ifdef OUTPUT_PORT_GRANT_TIMEOUT_EN
    cmp({tag, ".timeout"},  32'(timeout),  32'(m_to));
`endif
  endtask

  task automatic step(input logic [N-1:0] r, input logic [N-1:0] d, input string tag);
    req  = r;
    done = d;
    @(posedge clk);
    model_step(r, d);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    req = '0; done = '0;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check_all("reset");
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state
    do_reset();

    // Single request, grant, release
    step(16'h0001, 16'h0000, "single_grant");
    cmp("single_id_const", 32'(grant), 32'h0001);
    step(16'h0000, 16'h0001, "single_release");
    cmp("single_busy_const", 32'(busy), 32'd0);
    step(16'h0000, 16'h0000, "idle_no_req");

    // Full sweep with every input requesting
    do_reset();
    for (int i = 0; i <= N; i++) begin
      step(16'hFFFF, 16'h0000, "sweep_grant");
      cmp("sweep_id_const", 32'(grant_id), 32'(i % N));
      step(16'hFFFF, N'(1) << (i % N), "sweep_release");
    end

    // Pointer wrap: grant 4 then req 0x0011 must go to 0
    do_reset();
    step(16'h0010, 16'h0000, "wrap_grant4");
    step(16'h0000, 16'h0010, "wrap_release4");
    step(16'h0011, 16'h0000, "wrap_grant0");
    cmp("wrap_id_const", 32'(grant_id), 32'd0);
    step(16'h0000, 16'h0001, "wrap_release0");

    // Foreign done and dropped req ignored while holding
    step(16'h0008, 16'h0000, "hold_grant3");
    step(16'h0000, 16'h0004, "hold_foreign_done");
    cmp("hold_grant_const", 32'(grant), 32'h0008);
    step(16'h0000, 16'h0000, "hold_no_req");
    step(16'h0000, 16'h0008, "hold_release3");

    // Asynchronous reset mid-hold, between clock edges
    step(16'h0200, 16'h0000, "async_grant9");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    cmp("async_grant_zero", 32'(grant), 32'd0);
    cmp("async_busy_zero",  32'(busy),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(16'h8420, 16'h0000, "post_reset_grant");
    cmp("post_reset_lowest", 32'(grant_id), 32'd5);
    step(16'h0000, 16'h0020, "post_reset_release");

`ifdef OUTPUT_PORT_GRANT_TIMEOUT_EN
    // Hold limit: no done -> forced release with timeout pulse
    step(16'h0002, 16'h0000, "to_grant");
    for (int i = 0; i < MH; i++) step(16'h0000, 16'h0000, "to_hold");
    cmp("to_busy_before_limit", 32'(busy), 32'd1);
    step(16'h0000, 16'h0000, "to_expire");
    cmp("to_pulse_const", 32'(timeout), 32'd1);
    step(16'h0000, 16'h0000, "to_after");
    cmp("to_pulse_gone", 32'(timeout), 32'd0);
    // Done on the limit cycle is a normal release
    step(16'h0004, 16'h0000, "to_grant2");
    for (int i = 0; i < MH; i++) step(16'h0000, 16'h0000, "to_hold2");
    step(16'h0000, 16'h0004, "to_done_at_limit");
    cmp("to_no_pulse", 32'(timeout), 32'd0);
`endif

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] r, d;
      r = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom & $urandom);
      d = ($urandom_range(0, 1) == 0) ? N'($urandom & $urandom & $urandom) : '0;
      if (m_hold >= 0 && $urandom_range(0, 3) == 0) d = d | (N'(1) << m_hold);
      step(r, d, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
